// File: rtl/buffer_write_arbiter_pkg.sv
// Shared types and defaults for the CDC buffer write-side arbiters.
package buf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BURST      = 2'd1,
    WAIT_FULL  = 2'd2,
    WAIT_DRAIN = 2'd3
  } arb_state_t;

  localparam int DATA_W        = 16;
  localparam int BURST_LEN_DEF = 7;

endpackage

// File: rtl/buffer_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req searching from ptr+1 (mod N_REQ).
module rr_pick
  import buf_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any && req[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
          any = 1'b1;
          idx = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin burst arbiter feeding the clk_1 write port of the 8x16 CDC buffer;
// one requester owns the port for BURST_LEN words, then the buffer must drain.
module buffer_write_arbiter
  import buf_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = buf_arb_pkg::DATA_W,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                    clk_1,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    buf_empty_in,
  input  logic                    buf_full_in,
  output logic [DATA_W-1:0]       data_1_out,
  output logic                    data_1_en_out,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    burst_done
);

  localparam int              CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BURST_LEN);
  localparam logic [2:0]       PTR_RST  = 3'(N_REQ - 1);

  arb_state_t        state, state_n;
  logic [CNT_W-1:0]  count;
  logic [2:0]        ptr;
  logic [2:0]        pick_idx;
  logic              pick_any;
  logic              grant_load;
  logic              accept;
  logic              slot_open;
  logic [DATA_W-1:0] grant_word;
  logic              empty_m, empty_s, full_m, full_s;

  // Stage p0: two-flop synchronizers for the clk_2-domain buffer flags
  always_ff @(posedge clk_1) begin
    if (rst) begin
      empty_m <= 1'b1;
      empty_s <= 1'b1;
      full_m  <= 1'b0;
      full_s  <= 1'b0;
    end else begin
      empty_m <= buf_empty_in;
      empty_s <= empty_m;
      full_m  <= buf_full_in;
      full_s  <= full_m;
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Ready never looks at req_valid, so producers can gate valid on ready safely.
  assign slot_open = (state == BURST) && (count < CNT_END) && !full_s;

  always_comb begin
    req_ready  = '0;
    grant_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        req_ready[i] = slot_open;
        grant_word   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = |(req_ready & req_valid);
  assign busy   = (state != IDLE);

  always_comb begin
    state_n    = state;
    grant_load = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && empty_s && !full_s) begin
          state_n    = BURST;
          grant_load = 1'b1;
        end
      end
      BURST:      if (accept && (count == CNT_LAST)) state_n = WAIT_FULL;
      // Seeing empty fall first keeps a stale synchronized 'empty' from ending the wait.
      WAIT_FULL:  if (!empty_s) state_n = WAIT_DRAIN;
      WAIT_DRAIN: if (empty_s && !full_s) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Stage p1: registered write port toward the buffer, plus grant bookkeeping
  always_ff @(posedge clk_1) begin
    if (rst) begin
      count         <= '0;
      ptr           <= PTR_RST;
      grant_id      <= '0;
      data_1_out    <= '0;
      data_1_en_out <= 1'b0;
      burst_done    <= 1'b0;
    end else begin
      data_1_en_out <= accept;
      burst_done    <= accept && (count == CNT_LAST);
      if (accept) data_1_out <= grant_word;
      if (grant_load) begin
        grant_id <= pick_idx;
        ptr      <= pick_idx;
        count    <= '0;
      end else if (accept) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter with a behavioural 8-entry buffer that drains once full.
module tb_buffer_write_arbiter;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        buf_empty_in, buf_full_in;
  logic [15:0] data_1_out;
  logic        data_1_en_out;
  logic [2:0]  grant_id;
  logic        busy, burst_done;

  int   wc = 0;
  logic draining = 1'b0;
  logic force_full = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [3:0] vld;
    logic [2:0] g;
    int         mode;  // 0 plain, 1 valid gap, 2 forced full, 3 reset mid-burst
  } vec_t;
  vec_t vecs[11];

  buffer_write_arbiter #(.N_REQ(4), .DATA_W(16), .BURST_LEN(7)) dut (
    .clk_1         (clk_1),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .buf_empty_in  (buf_empty_in),
    .buf_full_in   (buf_full_in),
    .data_1_out    (data_1_out),
    .data_1_en_out (data_1_en_out),
    .grant_id      (grant_id),
    .busy          (busy),
    .burst_done    (burst_done)
  );

  always #5 clk_1 = ~clk_1;

  // Buffer model: fills on each write enable, drains one word per cycle once it reached 7.
  assign buf_empty_in = (wc == 0);
  assign buf_full_in  = force_full | (wc == 7);

  always @(posedge clk_1) begin
    if (rst) begin
      wc       <= 0;
      draining <= 1'b0;
    end else begin
      if (data_1_en_out) wc <= wc + 1;
      else if (draining) wc <= wc - 1;
      if (wc == 7) draining <= 1'b1;
      else if (wc <= 1) draining <= 1'b0;
    end
  end

  function automatic logic [15:0] lane_word(input int i, input int n);
    return 16'(i * 16'h1000 + n);
  endfunction

  task automatic drive_data(input int g, input int n);
    for (int i = 0; i < 4; i++)
      req_data[i*16 +: 16] = (i == g) ? lane_word(i, n) : (16'hF0F0 ^ 16'(i));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_burst(input logic [3:0] vld, input logic [2:0] g, input int mode);
    int n = 0;
    int cyc;
    int rel = 0;
    int extra = 0;
    bit got = 0;
    bit forcing = 0;
    bit hooked = 0;
    req_valid = vld;
    drive_data(g, 0);
    for (cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk_1);
      got = busy;
    end
    chk("grant_start", got, 1);
    if (!got) return;
    chk("grant_id", grant_id, g);
    chk("ready_onehot", req_ready, 32'(1) << g);
    cyc = 0;
    while (n < 7 && cyc < 80) begin
      @(negedge clk_1);
      cyc++;
      if (forcing) rel++;
      if (data_1_en_out) begin
        chk("data", data_1_out, lane_word(g, n));
        n++;
        chk("burst_done", burst_done, n == 7);
      end else begin
        chk("done_idle", burst_done, 0);
      end
      drive_data(g, n);
      if (mode == 1 && n == 3 && !hooked) begin
        hooked = 1;
        req_valid = 4'b0000;
        repeat (5) begin
          @(negedge clk_1);
          cyc++;
          chk("stall_en", data_1_en_out, 0);
          chk("stall_grant", grant_id, g);
        end
        req_valid = vld;
      end
      if (mode == 2 && n == 2 && !hooked) begin
        hooked = 1;
        force_full = 1'b1;
        forcing = 1;
      end
      if (forcing) begin
        if (rel == 1) chk("full_ready_lag", req_ready[g], 1);
        if (rel == 2) chk("full_ready_low", req_ready, 0);
        if (rel >= 3) chk("full_no_en", data_1_en_out, 0);
        if (rel == 7) begin
          force_full = 1'b0;
          forcing = 0;
        end
      end
      if (mode == 3 && n == 4) begin
        rst = 1'b1;
        @(negedge clk_1);
        chk("abort_en", data_1_en_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 0);
        chk("abort_grant", grant_id, 0);
        chk("abort_data", data_1_out, 0);
        chk("abort_done", burst_done, 0);
        rst = 1'b0;
        return;
      end
    end
    chk("burst_words", n, 7);
    got = 0;
    for (cyc = 0; cyc < 60 && !got; cyc++) begin
      @(negedge clk_1);
      if (data_1_en_out) extra++;
      got = !busy;
    end
    chk("drain_idle", got, 1);
    chk("no_overlap_en", extra, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'hF,    3'd0, 0};
    vecs[1]  = '{4'hF,    3'd1, 0};
    vecs[2]  = '{4'hF,    3'd2, 0};
    vecs[3]  = '{4'hF,    3'd3, 0};
    vecs[4]  = '{4'hF,    3'd0, 0};
    vecs[5]  = '{4'hF,    3'd1, 0};
    vecs[6]  = '{4'b0010, 3'd1, 0};
    vecs[7]  = '{4'b0100, 3'd2, 1};
    vecs[8]  = '{4'b0001, 3'd0, 2};
    vecs[9]  = '{4'b1000, 3'd3, 3};
    vecs[10] = '{4'hF,    3'd0, 0};

    rst = 1'b1;
    req_valid = 4'hF;
    req_data = '0;
    repeat (3) @(negedge clk_1);
    chk("rst_data", data_1_out, 0);
    chk("rst_en", data_1_en_out, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", burst_done, 0);
    rst = 1'b0;

    for (int v = 0; v < 11; v++)
      run_burst(vecs[v].vld, vecs[v].g, vecs[v].mode);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
